cart_bank_mapper: RTL and testbench
===================================

CART_BANK_MAPPER -- requirements
Module: cart_bank_mapper

Interface
REQ-001 Parameter BANK_BITS, default 3, width of bank register; legal range 1..3; max banks = 2^BANK_BITS.
REQ-002 Parameter SC_RAM, default 0, 1 = 128-byte Superchip RAM present.
REQ-003 CLOCKBUS  in  1  bus clock; one rising edge = one CPU bus cycle; sole clock.
REQ-004 RES  in  1  reset, asynchronous, active-high.
REQ-005 A  in  13  CPU address.
REQ-006 Din  in  8  CPU write data.
REQ-007 R_W_n  in  1  1 = read, 0 = write.
REQ-008 MODE  in  2  cartridge type: 0 = 4K plain, 1 = F8 (2 banks), 2 = F6 (4), 3 = F4 (8).
REQ-009 ROM_Dout  in  8  external ROM read data.
REQ-010 ROM_CS  out  1  external ROM select.
REQ-011 ROM_Addr  out  12+BANK_BITS  external ROM address {bank, A[11:0]}.
REQ-012 DOUT  out  8  cartridge read data to CPU bus mux.
REQ-013 BANK  out  BANK_BITS  current bank register.
REQ-014 MODE_EFF  out  2  latched effective mode.

Function
REQ-015 Cart region: A[12]=1; no action outside it (no switching, no RAM access, ROM_CS=0).
REQ-016 MODE_EFF loads MODE continuously while RES=1, holds after RES falls; MODE changes after reset have no effect.
REQ-017 If the latched MODE needs more than 2^BANK_BITS banks, MODE_EFF = 0.
REQ-018 Hotspots (any access, read or write): F8 $1FF8..$1FF9 -> bank 0..1; F6 $1FF6..$1FF9 -> 0..3; F4 $1FF4..$1FFB -> 0..7; mode 0 none.
REQ-019 BANK updates on the CLOCKBUS rising edge ending the hotspot cycle; the hotspot cycle itself uses the old bank; the next cycle uses the new bank (latency 1 cycle).
REQ-020 Repeated access to the hotspot of the current bank leaves BANK unchanged; back-to-back hotspots apply in order, one per cycle.
REQ-021 ROM_Addr = {BANK, A[11:0]} combinationally; mode 0 forces bank field to 0.
REQ-022 SC_RAM=1: write port $1000..$107F, read port $1080..$10FF; RAM index = A[6:0].
REQ-023 RAM write: R_W_n=0 in write port, Din stored on CLOCKBUS rising edge.
REQ-024 RAM read: R_W_n=1 in read port, DOUT = RAM[A[6:0]] combinationally, ROM_CS=0.
REQ-025 Read of write port or write to read port: no RAM change; ROM_CS=0, DOUT = 8'hFF.
REQ-026 ROM_CS=1 for every cart-region access not claimed by RAM (REQ-024/025); then DOUT = ROM_Dout.
REQ-027 Outside cart region DOUT = 8'hFF.
REQ-028 Writes to ROM space have no effect other than hotspot switching.
REQ-029 SC_RAM=0: $1000..$10FF is ordinary ROM space.

Reset
REQ-030 While RES=1: BANK = (banks of MODE_EFF) - 1 (F8 1, F6 3, F4 7, mode 0 0); ROM_CS, ROM_Addr, DOUT remain combinational per REQ-021/026/027.
REQ-031 RES asserted mid-operation forces BANK to its reset value immediately, without waiting for a clock; a hotspot in the same cycle is discarded.
REQ-032 RAM contents are not cleared by reset; undefined until written.

Verification
REQ-033 MODE=1, reset released, read $1000 -> ROM_Addr=13'h1000 (bank 1, BANK_BITS=1 view) / {3'd1,12'h000}; read $1FF8 -> that cycle bank 1, next cycle BANK=0.
REQ-034 MODE=3, BANK_BITS=3: reads $1FF4, $1FFB, $1FF7 consecutive -> BANK 0, 7, 3 one cycle after each.
REQ-035 MODE=3, BANK_BITS=2 -> MODE_EFF=0; read $1FF5 -> BANK stays 0, ROM_Addr={2'd0,12'hFF5}.
REQ-036 SC_RAM=1: write $1005 Din=8'hA5, read $1085 -> DOUT=8'hA5, ROM_CS=0; write $1085 8'h11 then read $1085 -> still 8'hA5.
REQ-037 MODE=2, switch to bank 0 via $1FF6, assert RES mid-cycle -> BANK=3 before next edge; change MODE to 1 after release -> MODE_EFF stays 2.
REQ-038 Write to $0FF8 (A[12]=0) in MODE=1 -> BANK unchanged, ROM_CS=0, DOUT=8'hFF.

Source files
------------

// File: rtl/cart_bank_mapper_if.sv
// Cartridge bus bundle: CPU address/data/direction plus the external ROM
// data path. The master side is the CPU/board, the slave side is the mapper.
interface cart_bank_mapper_if #(
  parameter int BANK_BITS = 3
);
  logic [12:0]            A;
  logic [7:0]             Din;
  logic                   R_W_n;
  logic [7:0]             ROM_Dout;
  logic                   ROM_CS;
  logic [11+BANK_BITS:0]  ROM_Addr;
  logic [7:0]             DOUT;

  modport master (
    output A, Din, R_W_n, ROM_Dout,
    input  ROM_CS, ROM_Addr, DOUT
  );

  modport slave (
    input  A, Din, R_W_n, ROM_Dout,
    output ROM_CS, ROM_Addr, DOUT
  );
endinterface

// File: rtl/cart_bank_mapper.sv
// Atari-style cartridge bank mapper: F8/F6/F4 hotspot bank switching over an
// external ROM, with optional 128-byte Superchip RAM (split write/read ports).
module cart_bank_mapper #(
  parameter int BANK_BITS = 3,
  parameter int SC_RAM    = 0
) (
  input  logic                 CLOCKBUS,
  input  logic                 RES,
  input  logic [1:0]           MODE,
  cart_bank_mapper_if.slave    bus,
  output logic [BANK_BITS-1:0] BANK,
  output logic [1:0]           MODE_EFF
);

  // A mode is usable only if its bank count fits the bank register.
  // Bank counts are 2^mode, so the test reduces to mode <= BANK_BITS.
  function automatic logic [1:0] f_mode_eff(input logic [1:0] mode);
    if (int'(mode) > BANK_BITS) return 2'd0;
    return mode;
  endfunction

  // Highest bank index of a mode; doubles as the reset bank and as the mask
  // that restricts the raw bank register to the active bank range.
  function automatic logic [2:0] f_bank_mask(input logic [1:0] mode);
    case (mode)
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      2'd3:    return 3'd7;
      default: return 3'd0;
    endcase
  endfunction

  logic [1:0]           w_mode_in;
  logic [1:0]           r_mode;
  logic [2:0]           w_mask_full;
  logic [BANK_BITS-1:0] w_mask;
  logic [BANK_BITS-1:0] r_bank;
  logic                 w_cart;
  logic                 w_hot;
  logic [BANK_BITS-1:0] w_hot_bank;
  logic [11:0]          w_base;
  logic [11:0]          w_span;
  logic [11:0]          w_off;
  logic                 w_ram_win;
  logic                 w_wr_port;
  logic                 w_rd_port;
  logic                 w_ram_wr;
  logic                 w_ram_rd;
  logic [7:0]           w_ram_q;

  assign w_cart    = bus.A[12];
  assign w_mode_in = f_mode_eff(MODE);

  // Mode capture: follows MODE every clock while reset is held and freezes
  // once reset drops. The output bypass makes MODE_EFF track MODE live while
  // reset is high; at least one clock edge inside reset captures the value.
  always_ff @(posedge CLOCKBUS) begin
    if (RES) r_mode <= w_mode_in;
  end

  assign MODE_EFF    = RES ? w_mode_in : r_mode;
  assign w_mask_full = f_bank_mask(MODE_EFF);
  assign w_mask      = w_mask_full[BANK_BITS-1:0];

  // Hotspot decode: a contiguous window of addresses whose offset from the
  // window base is the bank number to select.
  always_comb begin
    w_base = 12'hFFF;
    w_span = 12'd0;
    case (MODE_EFF)
      2'd1: begin w_base = 12'hFF8; w_span = 12'd2; end
      2'd2: begin w_base = 12'hFF6; w_span = 12'd4; end
      2'd3: begin w_base = 12'hFF4; w_span = 12'd8; end
      default: begin w_base = 12'hFFF; w_span = 12'd0; end
    endcase
    w_off      = bus.A[11:0] - w_base;
    w_hot      = w_cart && (bus.A[11:0] >= w_base) && (w_off < w_span);
    w_hot_bank = w_off[BANK_BITS-1:0];
  end

  // Bank register: reset loads all ones so that masking by the active mode
  // yields the mode's top bank immediately, with no clock needed. A hotspot
  // presented while reset is asserted is therefore lost.
  always_ff @(posedge CLOCKBUS or posedge RES) begin
    if (RES)        r_bank <= '1;
    else if (w_hot) r_bank <= w_hot_bank;
  end

  // Hotspot values never exceed the mask, so masking only matters for the
  // all-ones reset value; mode 0 collapses the bank field to zero.
  assign BANK         = r_bank & w_mask;
  assign bus.ROM_Addr = {BANK, bus.A[11:0]};

  // Superchip window: $1000-$10FF, lower half write port, upper half read port.
  assign w_ram_win = (SC_RAM != 0) && w_cart && (bus.A[11:8] == 4'h0);
  assign w_wr_port = w_ram_win && !bus.A[7];
  assign w_rd_port = w_ram_win &&  bus.A[7];
  assign w_ram_wr  = w_wr_port && !bus.R_W_n;
  assign w_ram_rd  = w_rd_port &&  bus.R_W_n;

  generate
    if (SC_RAM != 0) begin : g_ram
      logic [7:0] r_ram [0:127];

      // RAM write port; contents are never cleared by reset.
      always_ff @(posedge CLOCKBUS) begin
        if (w_ram_wr) r_ram[bus.A[6:0]] <= bus.Din;
      end

      assign w_ram_q = r_ram[bus.A[6:0]];
    end else begin : g_no_ram
      logic w_unused_ram;
      assign w_unused_ram = ^{bus.Din, w_ram_wr};
      assign w_ram_q      = 8'hFF;
    end
  endgenerate

  // Read data / ROM select: the RAM window claims the bus for both directions,
  // but only a read of the read port returns data; wrong-direction accesses
  // float high like an undriven bus.
  always_comb begin
    bus.ROM_CS = 1'b0;
    bus.DOUT   = 8'hFF;
    if (w_cart) begin
      if (w_ram_win) begin
        bus.ROM_CS = 1'b0;
        bus.DOUT   = w_ram_rd ? w_ram_q : 8'hFF;
      end else begin
        bus.ROM_CS = 1'b1;
        bus.DOUT   = bus.ROM_Dout;
      end
    end
  end

endmodule

// File: tb/tb_cart_bank_mapper.sv
module tb_cart_bank_mapper;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] mode_a;
  logic [1:0] mode_b;
  logic [2:0] bank_a;
  logic [1:0] bank_b;
  logic [1:0] meff_a;
  logic [1:0] meff_b;
  int         n_tests = 0;
  int         n_fail  = 0;

  always #5 clk = ~clk;

  cart_bank_mapper_if #(.BANK_BITS(3)) bus_a ();
  cart_bank_mapper_if #(.BANK_BITS(2)) bus_b ();

  cart_bank_mapper #(.BANK_BITS(3), .SC_RAM(1)) dut_a (
    .CLOCKBUS(clk), .RES(rst), .MODE(mode_a), .bus(bus_a.slave),
    .BANK(bank_a), .MODE_EFF(meff_a)
  );

  cart_bank_mapper #(.BANK_BITS(2), .SC_RAM(0)) dut_b (
    .CLOCKBUS(clk), .RES(rst), .MODE(mode_b), .bus(bus_b.slave),
    .BANK(bank_b), .MODE_EFF(meff_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step_a(input logic [12:0] a, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus_a.A = a; bus_a.R_W_n = rw; bus_a.Din = d;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mode_a = 2'd1; mode_b = 2'd3;
    bus_a.A = 13'h0000; bus_a.R_W_n = 1'b1; bus_a.Din = 8'h00; bus_a.ROM_Dout = 8'h3C;
    bus_b.A = 13'h0000; bus_b.R_W_n = 1'b1; bus_b.Din = 8'h00; bus_b.ROM_Dout = 8'h5A;
    tick; tick;
    check("rst_bank_f8", 32'(bank_a), 32'd1);
    check("rst_meff_f8", 32'(meff_a), 32'd1);
    check("rst_meff_b_clamp", 32'(meff_b), 32'd0);
    check("rst_bank_b", 32'(bank_b), 32'd0);

    @(negedge clk); rst = 1'b0;
    step_a(13'h1000, 1'b1, 8'h00);
    check("f8_addr_1000", 32'(bus_a.ROM_Addr), 32'h1000);
    check("rd_wrport_cs", 32'(bus_a.ROM_CS), 32'd0);
    check("rd_wrport_dout", 32'(bus_a.DOUT), 32'hFF);

    step_a(13'h1FF8, 1'b1, 8'h00);
    check("hot_old_bank", 32'(bank_a), 32'd1);
    check("hot_addr_old", 32'(bus_a.ROM_Addr), 32'h1FF8);
    check("rom_cs", 32'(bus_a.ROM_CS), 32'd1);
    check("rom_dout", 32'(bus_a.DOUT), 32'h3C);
    tick;
    check("f8_to_bank0", 32'(bank_a), 32'd0);

    step_a(13'h1FF9, 1'b0, 8'h77);
    tick;
    check("f8_wr_to_bank1", 32'(bank_a), 32'd1);
    step_a(13'h1FF9, 1'b1, 8'h00);
    tick;
    check("f8_repeat_hold", 32'(bank_a), 32'd1);

    step_a(13'h0FF8, 1'b0, 8'h00);
    check("outside_cs", 32'(bus_a.ROM_CS), 32'd0);
    check("outside_dout", 32'(bus_a.DOUT), 32'hFF);
    tick;
    check("outside_no_switch", 32'(bank_a), 32'd1);

    step_a(13'h1005, 1'b0, 8'hA5);
    tick;
    step_a(13'h1085, 1'b1, 8'h00);
    check("ram_rd_data", 32'(bus_a.DOUT), 32'hA5);
    check("ram_rd_cs", 32'(bus_a.ROM_CS), 32'd0);
    step_a(13'h1085, 1'b0, 8'h11);
    check("wr_rdport_dout", 32'(bus_a.DOUT), 32'hFF);
    check("wr_rdport_cs", 32'(bus_a.ROM_CS), 32'd0);
    tick;
    step_a(13'h1085, 1'b1, 8'h00);
    check("ram_unchanged", 32'(bus_a.DOUT), 32'hA5);

    // F4 sequence
    @(negedge clk); rst = 1'b1; mode_a = 2'd3;
    tick;
    check("rst_bank_f4", 32'(bank_a), 32'd7);
    @(negedge clk); rst = 1'b0;
    step_a(13'h1FF4, 1'b1, 8'h00);
    tick;
    check("f4_bank0", 32'(bank_a), 32'd0);
    step_a(13'h1FFB, 1'b1, 8'h00);
    check("f4_addr_old", 32'(bus_a.ROM_Addr), 32'h0FFB);
    tick;
    check("f4_bank7", 32'(bank_a), 32'd7);
    step_a(13'h1FF7, 1'b1, 8'h00);
    tick;
    check("f4_bank3", 32'(bank_a), 32'd3);

    // clamped mode on the narrow mapper, plus plain ROM at $1000 without RAM
    @(negedge clk); bus_b.A = 13'h1FF5; bus_b.R_W_n = 1'b1;
    #1;
    check("clamp_addr", 32'(bus_b.ROM_Addr), 32'h0FF5);
    tick;
    check("clamp_bank", 32'(bank_b), 32'd0);
    @(negedge clk); bus_b.A = 13'h1000;
    #1;
    check("noram_cs", 32'(bus_b.ROM_CS), 32'd1);
    check("noram_dout", 32'(bus_b.DOUT), 32'h5A);

    // F6 with reset asserted mid-cycle
    @(negedge clk); rst = 1'b1; mode_a = 2'd2;
    tick;
    @(negedge clk); rst = 1'b0;
    #1;
    check("rst_bank_f6", 32'(bank_a), 32'd3);
    step_a(13'h1FF6, 1'b1, 8'h00);
    tick;
    check("f6_bank0", 32'(bank_a), 32'd0);
    step_a(13'h1FF7, 1'b1, 8'h00);
    #2 rst = 1'b1;
    #1;
    check("async_rst_bank", 32'(bank_a), 32'd3);
    tick;
    check("rst_hot_discard", 32'(bank_a), 32'd3);
    @(negedge clk); rst = 1'b0; mode_a = 2'd1; bus_a.A = 13'h1FF8;
    #1;
    check("meff_hold", 32'(meff_a), 32'd2);
    tick;
    check("f6_still_active", 32'(bank_a), 32'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
